// File: rtl/regfile_pkg.sv
// Shared constants and FSM encoding for the register-file write arbiter.
package regfile_pkg;
  localparam int DATA_WIDTH = 8;
  localparam int NUM_REGS   = 4;
  localparam int SEL_WIDTH  = $clog2(NUM_REGS);
  localparam int CNT_WIDTH  = 8;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_e;
endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant; last_grant moves only when a grant is accepted.
module rr_arbiter2 (
  input  logic clk,
  input  logic rst_n,
  input  logic enable_i,
  input  logic req0_i,
  input  logic req1_i,
  input  logic accept_i,
  output logic gnt0_o,
  output logic gnt1_o
);
  logic last_grant_q, last_grant_d;

  always_comb begin
    gnt0_o = 1'b0;
    gnt1_o = 1'b0;
    if (enable_i) begin
      if (req0_i && req1_i) begin
        gnt0_o = last_grant_q;
        gnt1_o = !last_grant_q;
      end else begin
        gnt0_o = req0_i;
        gnt1_o = req1_i;
      end
    end
  end

  always_comb begin
    last_grant_d = last_grant_q;
    if (accept_i) last_grant_d = gnt1_o;
  end

  // Resets to port 1 so port 0 wins the first conflict.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_grant_q <= 1'b1;
    else        last_grant_q <= last_grant_d;
  end
endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the register-file write port between two requesters and runs a clear sweep.
module regfile_write_arbiter
  import regfile_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req0_valid,
  input  logic [SEL_WIDTH-1:0]  req0_dest,
  input  logic [DATA_WIDTH-1:0] req0_data,
  output logic                  req0_ready,
  input  logic                  req1_valid,
  input  logic [SEL_WIDTH-1:0]  req1_dest,
  input  logic [DATA_WIDTH-1:0] req1_data,
  output logic                  req1_ready,
  input  logic                  clear_req,
  output logic                  busy,
  output logic                  load_enable,
  output logic [SEL_WIDTH-1:0]  dest_select,
  output logic [DATA_WIDTH-1:0] reg_data,
  output logic [CNT_WIDTH-1:0]  conflict_count
);
  localparam logic [SEL_WIDTH-1:0] SWEEP_LAST = SEL_WIDTH'(NUM_REGS - 1);

  state_e                state_q, state_d;
  logic [SEL_WIDTH-1:0]  sweep_q, sweep_d;
  logic                  load_q, load_d;
  logic [SEL_WIDTH-1:0]  dest_q, dest_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic                  arb_en, gnt0, gnt1;

  // Clear takes priority over requests in the cycle it is sampled.
  assign arb_en = reset && (state_q == ST_IDLE) && !clear_req;

  rr_arbiter2 u_arb (
    .clk      (clk),
    .rst_n    (reset),
    .enable_i (arb_en),
    .req0_i   (req0_valid),
    .req1_i   (req1_valid),
    .accept_i (gnt0 || gnt1),
    .gnt0_o   (gnt0),
    .gnt1_o   (gnt1)
  );

  assign req0_ready     = gnt0;
  assign req1_ready     = gnt1;
  assign busy           = (state_q == ST_CLEAR);
  assign load_enable    = load_q;
  assign dest_select    = dest_q;
  assign reg_data       = data_q;
  assign conflict_count = cnt_q;

  always_comb begin
    state_d = state_q;
    sweep_d = sweep_q;
    load_d  = 1'b0;
    dest_d  = dest_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    if (req0_valid && req1_valid && (cnt_q != CNT_MAX)) cnt_d = cnt_q + CNT_WIDTH'(1);
    case (state_q)
      ST_IDLE: begin
        if (clear_req) begin
          state_d = ST_CLEAR;
          sweep_d = '0;
        end else if (gnt0) begin
          load_d = 1'b1;
          dest_d = req0_dest;
          data_d = req0_data;
        end else if (gnt1) begin
          load_d = 1'b1;
          dest_d = req1_dest;
          data_d = req1_data;
        end
      end
      ST_CLEAR: begin
        load_d  = 1'b1;
        dest_d  = sweep_q;
        data_d  = '0;
        sweep_d = sweep_q + SEL_WIDTH'(1);
        if (sweep_q == SWEEP_LAST) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      sweep_q <= '0;
      load_q  <= 1'b0;
      dest_q  <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sweep_q <= sweep_d;
      load_q  <= load_d;
      dest_q  <= dest_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
    end
  end
endmodule
